// File: rtl/lpddr2_avl_responder.sv
// lpddr2_avl_responder: behavioural Avalon-MM responder standing in for the
// LPDDR2 controller port 0. On-chip RAM backs the port; the model covers init
// delay, periodic waitrequest stalls, burst writes, fixed-latency burst reads
// and a sticky flag for initiator protocol violations.
module lpddr2_avl_responder #(
    parameter int MEM_AW       = 12,
    parameter int INIT_CYCLES  = 64,
    parameter int READ_LATENCY = 4,
    parameter int STALL_PERIOD = 0
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    output logic        avl_ready,
    input  logic        avl_burstbegin,
    input  logic [26:0] avl_addr,
    input  logic [31:0] avl_wdata,
    input  logic [3:0]  avl_be,
    input  logic        avl_read_req,
    input  logic        avl_write_req,
    input  logic [2:0]  avl_size,
    output logic        avl_rdata_valid,
    output logic [31:0] avl_rdata,
    output logic        local_init_done,
    output logic        protocol_err
);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WBURST, S_RDWAIT} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     init_cnt_q, init_cnt_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [MEM_AW-1:0] wr_next_q, wr_next_d;
    logic [2:0]        wr_left_q, wr_left_d;
    logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        rd_left_q, rd_left_d;
    logic [3:0]        rd_wait_q, rd_wait_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              perr_q, perr_d;

    logic [31:0]       mem [2**MEM_AW];

    logic              stall;
    logic              ready;
    logic              wr_en;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] cmd_idx;
    logic [2:0]        eff_size;

    // burstbegin is informational and high address bits alias onto the RAM.
    logic unused_ok;
    assign unused_ok = &{1'b0, avl_burstbegin, avl_addr[26:MEM_AW]};

    assign cmd_idx  = avl_addr[MEM_AW-1:0];
    assign eff_size = (avl_size == 3'd0) ? 3'd1 : avl_size;
    assign stall    = (STALL_PERIOD != 0) && (stall_cnt_q == SW'(STALL_PERIOD - 1));

    assign avl_ready       = ready;
    assign avl_rdata_valid = rdata_valid_q;
    assign avl_rdata       = rdata_q;
    assign local_init_done = (state_q != S_INIT);
    assign protocol_err    = perr_q;

    // Next-state, handshake and RAM-port decode for the command FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        wr_next_d     = wr_next_q;
        wr_left_d     = wr_left_q;
        rd_addr_d     = rd_addr_q;
        rd_left_d     = rd_left_q;
        rd_wait_d     = rd_wait_q;
        rdata_valid_d = 1'b0;
        rdata_d       = rdata_q;
        perr_d        = perr_q;
        ready         = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = wr_next_q;

        if (STALL_PERIOD != 0) begin
            stall_cnt_d = stall ? '0 : stall_cnt_q + SW'(1);
        end

        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + IW'(1);
                if (avl_read_req || avl_write_req) perr_d = 1'b1;
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                ready = !stall;
                if (ready && avl_write_req) begin
                    // A write wins over a simultaneous read; the read is dropped.
                    wr_en  = 1'b1;
                    wr_idx = cmd_idx;
                    if (avl_read_req || avl_size == 3'd0) perr_d = 1'b1;
                    if (eff_size > 3'd1) begin
                        state_d   = S_WBURST;
                        wr_left_d = eff_size - 3'd1;
                        wr_next_d = cmd_idx + MEM_AW'(1);
                    end
                end else if (ready && avl_read_req) begin
                    if (avl_size == 3'd0) perr_d = 1'b1;
                    state_d   = S_RDWAIT;
                    rd_addr_d = cmd_idx;
                    rd_left_d = eff_size;
                    rd_wait_d = 4'(READ_LATENCY - 2);
                end
            end
            S_WBURST: begin
                ready = !stall;
                if (avl_read_req) perr_d = 1'b1;
                if (ready && avl_write_req) begin
                    wr_en     = 1'b1;
                    wr_next_d = wr_next_q + MEM_AW'(1);
                    wr_left_d = wr_left_q - 3'd1;
                    if (wr_left_q == 3'd1) state_d = S_IDLE;
                end
            end
            S_RDWAIT: begin
                // Beats are registered one edge early so rdata_valid is a flop output.
                if (rd_wait_q != 4'd0) begin
                    rd_wait_d = rd_wait_q - 4'd1;
                end else if (rd_left_q != 3'd0) begin
                    rdata_valid_d = 1'b1;
                    rdata_d       = mem[rd_addr_q];
                    rd_addr_d     = rd_addr_q + MEM_AW'(1);
                    rd_left_d     = rd_left_q - 3'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control and read-data registers; reset abandons any burst in flight.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!iRST_n) begin
            state_q       <= S_INIT;
            init_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            wr_next_q     <= '0;
            wr_left_q     <= '0;
            rd_addr_q     <= '0;
            rd_left_q     <= '0;
            rd_wait_q     <= '0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            wr_next_q     <= wr_next_d;
            wr_left_q     <= wr_left_d;
            rd_addr_q     <= rd_addr_d;
            rd_left_q     <= rd_left_d;
            rd_wait_q     <= rd_wait_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            perr_q        <= perr_d;
        end
    end

    // Byte-enabled RAM write port.
    always_ff @(posedge iCLK) begin
        // NOTE: the RAM is deliberately left out of reset so its contents survive iRST_n.
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (avl_be[b]) mem[wr_idx][8*b +: 8] <= avl_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lpddr2_avl_responder.sv
// Testbench for lpddr2_avl_responder: randomized and directed traffic against
// a word-array reference model; a scoreboard queue holds expected read beats
// (data plus the edge they must appear on) and a monitor pops and compares.
module tb_lpddr2_avl_responder;
    localparam int MEM_AW = 12;
    localparam int INIT   = 64;
    localparam int RL     = 4;
    localparam int SP     = 3;
    localparam int MASK   = (1 << MEM_AW) - 1;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b1;
    logic        avl_ready;
    logic        avl_burstbegin;
    logic [26:0] avl_addr;
    logic [31:0] avl_wdata;
    logic [3:0]  avl_be;
    logic        avl_read_req;
    logic        avl_write_req;
    logic [2:0]  avl_size;
    logic        avl_rdata_valid;
    logic [31:0] avl_rdata;
    logic        local_init_done;
    logic        protocol_err;

    always #5 iCLK = ~iCLK;

    lpddr2_avl_responder #(
        .MEM_AW(MEM_AW), .INIT_CYCLES(INIT), .READ_LATENCY(RL), .STALL_PERIOD(SP)
    ) u_dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .avl_ready(avl_ready),
        .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
        .avl_be(avl_be), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
        .avl_size(avl_size), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .local_init_done(local_init_done), .protocol_err(protocol_err)
    );

    typedef struct {
        int          edge_no;
        logic [31:0] data;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    int          edge_n;
    logic [31:0] ref_mem [1 << MEM_AW];
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    beat_t       exp_q [$];

    // Rising edges since reset release; edge 1 is the first edge with iRST_n high.
    always @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // The stall counter starts at reset release, so the edge u is a stall edge
    // when (u-1) mod SP is the last count.
    function automatic bit stall_at(input int u);
        return ((u - 1) % SP) == (SP - 1);
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[idx & MASK][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_bus();
        avl_read_req   = 1'b0;
        avl_write_req  = 1'b0;
        avl_burstbegin = 1'b0;
        avl_addr       = '0;
        avl_wdata      = '0;
        avl_be         = '0;
        avl_size       = 3'd1;
    endtask

    // Issue n write beats from wd/wbe; beats after the first carry junk addr/size.
    task automatic write_cmd(input int addr, input int n, input logic [2:0] sz,
                             input bit rd_first, input bit rd_later);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited         = 0;
            avl_write_req  = 1'b1;
            avl_read_req   = (i == 0) ? rd_first : rd_later;
            avl_burstbegin = (i == 0);
            avl_addr       = (i == 0) ? {15'($urandom), 12'(addr)} : 27'($urandom);
            avl_size       = (i == 0) ? sz : 3'($urandom);
            avl_wdata      = wd[i];
            avl_be         = wbe[i];
            check("ready_wr", 32'(avl_ready), 32'(!stall_at(edge_n + 1)));
            while (!avl_ready && waited < 8) begin
                tick();
                waited++;
                check("ready_wr", 32'(avl_ready), 32'(!stall_at(edge_n + 1)));
            end
            if (!avl_ready) check("wr_accept_timeout", 32'(avl_ready), 32'd1);
            else            model_write(addr + i, wd[i], wbe[i]);
            tick();
        end
        idle_bus();
    endtask

    // Issue one read command; expected beats go to the scoreboard. A nonzero
    // abort_after returns that many edges after accept, mid-RDWAIT.
    task automatic read_cmd(input int addr, input logic [2:0] sz, input int abort_after);
        int n;
        int t;
        int waited;
        beat_t b;
        n              = (sz == 3'd0) ? 1 : int'(sz);
        waited         = 0;
        avl_read_req   = 1'b1;
        avl_write_req  = 1'b0;
        avl_burstbegin = 1'b1;
        avl_addr       = {15'($urandom), 12'(addr)};
        avl_size       = sz;
        avl_wdata      = $urandom;
        avl_be         = 4'($urandom);
        check("ready_rd_cmd", 32'(avl_ready), 32'(!stall_at(edge_n + 1)));
        while (!avl_ready && waited < 8) begin
            tick();
            waited++;
        end
        if (!avl_ready) begin
            check("rd_accept_timeout", 32'(avl_ready), 32'd1);
            idle_bus();
            return;
        end
        tick();
        t = edge_n;
        idle_bus();
        for (int i = 0; i < n; i++) begin
            b.edge_no = t + RL + i;
            b.data    = ref_mem[(addr + i) & MASK];
            exp_q.push_back(b);
        end
        for (int u = t + 1; u <= t + RL + n; u++) begin
            if (abort_after != 0 && u > t + abort_after) return;
            check("ready_rd", 32'(avl_ready), (u == t + RL + n) ? 32'(!stall_at(u)) : 32'd0);
            if (u < t + RL + n) tick();
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            tick();
            waited++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every visible beat must match the head of the queue.
    always @(negedge iCLK) begin
        if (iRST_n && avl_rdata_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdata_valid", 32'(avl_rdata_valid), 32'd0);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("rdata", avl_rdata, b.data);
                check("rdata_edge", 32'(edge_n + 1), 32'(b.edge_no));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        for (int i = 0; i <= MASK; i++) ref_mem[i] = '0;
        #1 iRST_n = 1'b0;
        #2;
        check("rst_ready", 32'(avl_ready), 32'd0);
        check("rst_rdata_valid", 32'(avl_rdata_valid), 32'd0);
        check("rst_rdata", avl_rdata, 32'd0);
        check("rst_init_done", 32'(local_init_done), 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        tick();
        while (edge_n < INIT - 1) tick();
        check("init_done_early", 32'(local_init_done), 32'd0);
        check("ready_during_init", 32'(avl_ready), 32'd0);
        tick();
        check("init_done", 32'(local_init_done), 32'd1);
        check("ready_at_init_done", 32'(avl_ready), 32'(!stall_at(edge_n + 1)));

        // Single write then single read.
        wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
        write_cmd(32'h10, 1, 3'd1, 1'b0, 1'b0);
        read_cmd(32'h10, 3'd1, 0);
        drain();

        // Burst across the top of the RAM wraps to word 0.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wbe[i] = 4'hF; end
        write_cmd(32'hFFE, 4, 3'd4, 1'b0, 1'b0);
        read_cmd(32'hFFE, 3'd4, 0);
        drain();

        // Byte-enable merge.
        wd[0] = 32'h11223344; wbe[0] = 4'hF;
        write_cmd(32'h20, 1, 3'd1, 1'b0, 1'b0);
        wd[0] = 32'hAABBCCDD; wbe[0] = 4'b0101;
        write_cmd(32'h20, 1, 3'd1, 1'b0, 1'b0);
        read_cmd(32'h20, 3'd1, 0);
        drain();

        // Seven-beat burst through the periodic stalls.
        for (int i = 0; i < 7; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
        write_cmd(32'h100, 7, 3'd7, 1'b0, 1'b0);
        read_cmd(32'h100, 3'd7, 0);
        drain();

        // Fill the random window around the wrap point, plus a word for later.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 7; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
            write_cmd((32'hFF0 + 7 * k) & MASK, 7, 3'd7, 1'b0, 1'b0);
        end
        wd[0] = $urandom; wbe[0] = 4'hF;
        write_cmd(32'h40, 1, 3'd1, 1'b0, 1'b0);

        // Random mix of write bursts (random byte enables) and read bursts.
        for (int op = 0; op < 40; op++) begin
            int a;
            int n;
            a = (32'hFF0 + $urandom_range(0, 24)) & MASK;
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) begin wd[i] = $urandom; wbe[i] = 4'($urandom); end
                write_cmd(a, n, 3'(n), 1'b0, 1'b0);
            end else begin
                read_cmd(a, 3'(n), 0);
            end
        end
        drain();

        // Protocol violations.
        check("perr_clean", 32'(protocol_err), 32'd0);
        wd[0] = $urandom; wbe[0] = 4'hF;
        write_cmd(32'h30, 1, 3'd1, 1'b1, 1'b0);
        check("perr_rd_wr", 32'(protocol_err), 32'd1);
        read_cmd(32'h30, 3'd1, 0);
        drain();

        wd[0] = $urandom; wbe[0] = 4'hF;
        write_cmd(32'h31, 1, 3'd0, 1'b0, 1'b0);
        read_cmd(32'h31, 3'd0, 0);
        drain();

        for (int i = 0; i < 3; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
        write_cmd(32'h50, 3, 3'd3, 1'b0, 1'b1);
        read_cmd(32'h50, 3'd3, 0);
        drain();

        // Reset in the middle of a read burst.
        read_cmd(32'h100, 3'd7, 2);
        iRST_n = 1'b0;
        exp_q.delete();
        #2;
        check("rst2_rdata_valid", 32'(avl_rdata_valid), 32'd0);
        check("rst2_rdata", avl_rdata, 32'd0);
        check("rst2_protocol_err", 32'(protocol_err), 32'd0);
        check("rst2_init_done", 32'(local_init_done), 32'd0);
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        tick();
        check("rst2_perr_after_release", 32'(protocol_err), 32'd0);

        // A command during init is ignored but flagged.
        while (edge_n < 10) tick();
        avl_write_req = 1'b1;
        avl_addr      = 27'h40;
        avl_wdata     = ~ref_mem[32'h40];
        avl_be        = 4'hF;
        avl_size      = 3'd1;
        tick();
        idle_bus();
        check("perr_init_cmd", 32'(protocol_err), 32'd1);
        while (edge_n < INIT) tick();
        check("rst2_init_done_high", 32'(local_init_done), 32'd1);

        read_cmd(32'h40, 3'd1, 0);
        read_cmd(32'h10, 3'd1, 0);
        read_cmd(32'hFFE, 3'd4, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
